clkdiv_multi: RTL

- Parametrised, multi-channel successor to the team's fixed power-of-two clock divider.
- Each channel has a runtime-programmable divisor, an enable, and a per-channel output mode (square-wave toggle or single-cycle pulse).
- Each channel also drives a one-cycle tick usable as a clock enable.
- Divisor changes are shadowed and applied only at a period boundary, so outputs never glitch.
- Sits between the board clock and slow logic (debouncers, display scan, LED blink).

---
 rtl/clkdiv_pkg.sv | 10 +
 rtl/clkdiv_chan.sv | 91 +++++++++
 rtl/clkdiv_multi.sv | 37 +++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned DEF_WIDTH = 21;
  localparam int unsigned DEF_DIV   = 1048576;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: free-running counter, active/pending divisor and
// registered clk_out/tick/pend outputs.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             running;
  logic             last;

  assign running = en && (act_q != '0);
  assign last    = (count_q == (act_q - WIDTH'(1)));

  always_comb begin
    count_d   = count_q;
    act_d     = act_q;
    pdiv_d    = pdiv_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;

    if (!running) begin
      // Idle or stalled channel: nothing to protect, so a load takes effect now.
      if (!en && mode == MODE_PULSE) clk_out_d = 1'b0;
      if (load) begin
        act_d   = div_in;
        count_d = '0;
        pend_d  = 1'b0;
      end
    end else if (last) begin
      count_d   = '0;
      tick_d    = 1'b1;
      clk_out_d = (mode == MODE_PULSE) ? 1'b1 : ~clk_out_q;
      if (load) begin
        act_d  = div_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        act_d  = pdiv_q;
        pend_d = 1'b0;
      end
    end else begin
      count_d = count_q + WIDTH'(1);
      if (mode == MODE_PULSE) clk_out_d = 1'b0;
      if (load) begin
        pdiv_d = div_in;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= '0;
      act_q     <= DEFAULT_DIV;
      pdiv_q    <= '0;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      act_q     <= act_d;
      pdiv_q    <= pdiv_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider; channel i uses div_in[i*WIDTH +: WIDTH].
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     en,
  input  logic [NCH-1:0]     load,
  input  logic [NCH*WIDTH-1:0] div_in,
  input  logic [NCH-1:0]     mode,
  output logic [NCH-1:0]     clk_out,
  output logic [NCH-1:0]     tick,
  output logic [NCH-1:0]     pend
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clkdiv_chan #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(WIDTH'(DEFAULT_DIV))
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .load   (load[i]),
      .div_in (div_in[i*WIDTH +: WIDTH]),
      .mode   (mode[i]),
      .clk_out(clk_out[i]),
      .tick   (tick[i]),
      .pend   (pend[i])
    );
  end

endmodule
